// File: rtl/fifo_pkg.sv
// Shared constants and types for the depth-8 x 8-bit FIFO buffer.
package fifo_pkg;

  localparam int FIFO_WIDTH  = 8;
  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_ADDR_W = 3;

  typedef logic [FIFO_WIDTH-1:0] word_t;
  // One extra MSB acts as the wrap bit that separates full from empty.
  typedef logic [FIFO_ADDR_W:0]  ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array with a synchronous write port and a registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array with asynchronous clear of every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
    end
  end

  // Registered read data; holds its value whenever no read is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else begin
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/fifo_buffer.sv
// Single-clock FIFO: wrap-bit pointers, full/empty flags and request qualification around fifo_mem.
module fifo_buffer
  import fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic             ren,
  input  logic [WIDTH-1:0] w_word,
  output logic [WIDTH-1:0] r_word,
  output logic             full,
  output logic             empty
);

  logic [ADDR_W:0] w_ptr;
  logic [ADDR_W:0] r_ptr;
  logic            wr_ok;
  logic            rd_ok;

  // Flags from the registered pointers; requests are qualified against pre-edge flags.
  always_comb begin
    empty = (w_ptr == r_ptr);
    full  = (w_ptr[ADDR_W] != r_ptr[ADDR_W]) &&
            (w_ptr[ADDR_W-1:0] == r_ptr[ADDR_W-1:0]);
    wr_ok = wen && !full;
    rd_ok = ren && !empty;
  end

  // Write pointer; natural modulo-2^(ADDR_W+1) wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr <= '0;
    end else begin
      if (wr_ok) begin
        w_ptr <= w_ptr + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Read pointer; natural modulo-2^(ADDR_W+1) wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else begin
      if (rd_ok) begin
        r_ptr <= r_ptr + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Read and write addresses only coincide when empty or full, so they never collide here.
  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (w_ptr[ADDR_W-1:0]),
    .wdata (w_word),
    .re    (rd_ok),
    .raddr (r_ptr[ADDR_W-1:0]),
    .rdata (r_word)
  );

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed self-checking bench for fifo_buffer using immediate assertions.
module tb_fifo_buffer;
  import fifo_pkg::*;

  logic  clk;
  logic  rst;
  logic  wen;
  logic  ren;
  word_t w_word;
  word_t r_word;
  logic  full;
  logic  empty;

  int n_assert = 0;
  int n_fail   = 0;

  fifo_buffer dut (
    .clk    (clk),
    .rst    (rst),
    .wen    (wen),
    .ren    (ren),
    .w_word (w_word),
    .r_word (r_word),
    .full   (full),
    .empty  (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ptrs(input string tag, input int wp, input int rp);
    chk({tag, "_wptr"}, 32'(dut.w_ptr), 32'(wp));
    chk({tag, "_rptr"}, 32'(dut.r_ptr), 32'(rp));
  endtask

  initial begin
    rst = 1'b0; wen = 1'b0; ren = 1'b0; w_word = 8'h00;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rword", 32'(r_word), 32'd0);
    chk_ptrs("rst", 0, 0);
    rst = 1'b1;
    step();
    chk("idle_empty", 32'(empty), 32'd1);

    // Fill 1..8
    for (int i = 1; i <= 8; i++) begin
      wen = 1'b1; w_word = 8'(i);
      step();
      if (i == 1) chk("fill1_empty", 32'(empty), 32'd0);
      if (i == 7) chk("fill7_full", 32'(full), 32'd0);
    end
    chk("fill8_full", 32'(full), 32'd1);
    chk_ptrs("fill8", 8, 0);
    w_word = 8'd9;
    step();
    chk("fill9_full", 32'(full), 32'd1);
    chk_ptrs("fill9", 8, 0);
    wen = 1'b0;

    // Drain 1..8, then one blocked read
    for (int i = 1; i <= 8; i++) begin
      ren = 1'b1;
      step();
      chk("drain_data", 32'(r_word), 32'(i));
      if (i == 7) chk("drain7_empty", 32'(empty), 32'd0);
    end
    chk("drain8_empty", 32'(empty), 32'd1);
    step();
    chk("drain_blocked_rword", 32'(r_word), 32'd8);
    chk_ptrs("drain_blocked", 8, 8);
    ren = 1'b0;

    // Concurrent: occupancy 4 then simultaneous read/write
    for (int i = 1; i <= 4; i++) begin
      wen = 1'b1; w_word = 8'(i);
      step();
    end
    for (int i = 1; i <= 6; i++) begin
      wen = 1'b1; ren = 1'b1; w_word = 8'(i + 4);
      step();
      chk("conc_data", 32'(r_word), 32'(i));
      chk("conc_full", 32'(full), 32'd0);
      chk("conc_empty", 32'(empty), 32'd0);
    end
    wen = 1'b0;
    chk_ptrs("conc", 2, 14);
    for (int i = 7; i <= 10; i++) begin
      ren = 1'b1;
      step();
      chk("conc_tail", 32'(r_word), 32'(i));
    end
    ren = 1'b0;
    chk("conc_end_empty", 32'(empty), 32'd1);

    // Async reset between edges to start wrap test from zero pointers
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk_ptrs("rst2", 0, 0);
    rst = 1'b1;
    step();

    // Wrap-around
    for (int i = 1; i <= 8; i++) begin
      wen = 1'b1; w_word = 8'(i);
      step();
    end
    wen = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ren = 1'b1;
      step();
      chk("wrap_rd1", 32'(r_word), 32'(i));
    end
    ren = 1'b0;
    for (int i = 9; i <= 12; i++) begin
      wen = 1'b1; w_word = 8'(i);
      step();
    end
    wen = 1'b0;
    chk("wrap_full", 32'(full), 32'd1);
    chk_ptrs("wrap_full", 12, 4);

    // Simultaneous request while full: only the read happens
    wen = 1'b1; ren = 1'b1; w_word = 8'h99;
    step();
    wen = 1'b0; ren = 1'b0;
    chk("full_rw_data", 32'(r_word), 32'd5);
    chk_ptrs("full_rw", 12, 5);
    chk("full_rw_full", 32'(full), 32'd0);
    for (int i = 6; i <= 12; i++) begin
      ren = 1'b1;
      step();
      chk("wrap_rd2", 32'(r_word), 32'(i));
    end
    ren = 1'b0;
    chk("wrap_end_empty", 32'(empty), 32'd1);

    // Simultaneous request while empty: only the write happens, no bypass
    wen = 1'b1; ren = 1'b1; w_word = 8'h55;
    step();
    wen = 1'b0; ren = 1'b0;
    chk("empty_rw_rword", 32'(r_word), 32'd12);
    chk("empty_rw_empty", 32'(empty), 32'd0);
    chk_ptrs("empty_rw", 13, 12);
    ren = 1'b1;
    step();
    ren = 1'b0;
    chk("empty_rw_read", 32'(r_word), 32'h55);

    // Mid-operation reset with 5 entries stored
    for (int i = 0; i < 5; i++) begin
      wen = 1'b1; w_word = 8'(8'hA1 + i);
      step();
    end
    wen = 1'b0;
    chk("mid_pre_empty", 32'(empty), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_full", 32'(full), 32'd0);
    chk("mid_rword", 32'(r_word), 32'd0);
    chk_ptrs("mid", 0, 0);
    #1;
    rst = 1'b1;
    ren = 1'b1;
    step();
    ren = 1'b0;
    chk("mid_blocked_rword", 32'(r_word), 32'd0);
    chk_ptrs("mid_blocked", 0, 0);
    wen = 1'b1; w_word = 8'h3C;
    step();
    wen = 1'b0; ren = 1'b1;
    step();
    ren = 1'b0;
    chk("mid_new_read", 32'(r_word), 32'h3C);
    chk("mid_new_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
- Single-clock, depth-8 × 8-bit first-in-first-out buffer with full/empty flags.
- Decouples a producer and a consumer that share one clock but issue writes and reads independently.
- Storage is a small dual-port register array.
- Read and write pointers carry an extra wrap bit so full and empty can be distinguished.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of entries; must be a power of two.
- ADDR_W, 3, log2(DEPTH); pointer width is ADDR_W+1.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- wen  input  1  write request.
- ren  input  1  read request.
- w_word  input  WIDTH  write data.
- r_word  output  WIDTH  read data (registered).
- full  output  1  buffer holds DEPTH entries.
- empty  output  1  buffer holds 0 entries.

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately):
  - write pointer w_ptr = 0, read pointer r_ptr = 0.
  - r_word = 0; every memory entry = 0.
  - Outputs: empty = 1, full = 0.
  - Holds while rst is low; normal operation resumes on the first rising clk edge after rst goes high.
- Pointers: w_ptr and r_ptr are (ADDR_W+1)-bit binary counters.
  - Memory address = low ADDR_W bits.
  - MSB is the wrap bit; increment is modulo 2^(ADDR_W+1), so natural wrap.
- Flags are combinational from the registered pointers:
  - empty = (w_ptr == r_ptr).
  - full = (w_ptr[ADDR_W] != r_ptr[ADDR_W]) && (low bits equal).
  - Both flags reflect an operation one edge after that operation.
- Write: on the rising edge with wen=1 and full=0:
  - mem[w_ptr[ADDR_W-1:0]] <= w_word;
  - w_ptr increments.
- Write blocked: wen=1 while full=1 is ignored. Memory and w_ptr are unchanged; no error flag.
- Read: on the rising edge with ren=1 and empty=0:
  - r_word <= mem[r_ptr[ADDR_W-1:0]];
  - r_ptr increments.
  - Latency: data is valid on r_word immediately after the edge that accepts the read.
- Read blocked: ren=1 while empty=1 is ignored; r_word holds its previous value and r_ptr is unchanged.
- r_word holds its last value whenever no read is accepted.
- Simultaneous wen & ren:
  - Each is qualified independently against the flags sampled before the edge.
  - When neither flag is set, both occur and occupancy is unchanged.
  - When full: only the read occurs; the write is dropped.
  - When empty: only the write occurs; the read is dropped and r_word does not bypass.
- Occupancy = w_ptr − r_ptr (mod 2^(ADDR_W+1)); always in the range 0..DEPTH.
- Reset asserted mid-operation discards all contents immediately; there is no partial recovery.

Decomposition:
- Shared package fifo_pkg holds:
  - constants FIFO_WIDTH=8, FIFO_DEPTH=8, FIFO_ADDR_W=3;
  - typedef word_t (logic [WIDTH-1:0]);
  - typedef ptr_t (logic [ADDR_W:0]).
- One sub-module fifo_mem: DEPTH×WIDTH register array.
  - Synchronous write port: we, waddr, wdata.
  - Registered read port: re, raddr, rdata.
  - Asynchronous clear on rst.
- Top level holds the pointers, the flag logic and the qualification of wen/ren.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release -> empty=1, full=0, r_word=0, pointers 0.
- Fill: write 1..8 on consecutive edges with ren=0 -> empty=0 after the first write; full=1 after the 8th; a 9th write of value 9 is ignored, w_ptr stays 8.
- Drain: from full, ren=1 for 8 edges -> r_word sequence 1,2,…,8; empty=1 after the 8th; a further read leaves r_word=8.
- Concurrent: wen=ren=1 every edge with occupancy 4 (contents 1..4), writing 5,6,7,… -> reads return 1,2,3,… in order; full and empty stay 0.
- Wrap-around: write 1..8, read 4 (returns 1..4), write 9..12, read 8 -> data 5..12; full=1 at occupancy 8 with w_ptr=12, r_ptr=4.
- Mid-operation reset: with 5 entries stored, pulse rst low asynchronously between edges -> empty=1 and full=0 immediately; reads then blocked until new writes.
